// File: rtl/serial_to_parallel_stream_pkg.sv
// Shared constants and sizing helpers for the serial_to_parallel_stream deserialiser.
package serial_to_parallel_stream_pkg;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  function automatic int beats(int width, int lane);
    return width / lane;
  endfunction

  // Bits needed to hold a beat count in the range 0..n_beats.
  function automatic int count_width(int n_beats);
    return $clog2(n_beats + 1);
  endfunction

endpackage

// File: rtl/s2p_out_slot.sv
// Single-entry valid/ready output register: a load wins over a take, so a word
// can be replaced in the same cycle it is consumed.
module s2p_out_slot
  import serial_to_parallel_stream_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [dw-1:0] load_data,
  input  logic          take,
  output logic          valid,
  output logic [dw-1:0] data,
  output logic          slot_free
);

  assign slot_free = !valid || take;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Packs lane-bit serial beats into width-bit words behind a registered valid/ready output.
// Optional partial-word flush is compiled in with SERIAL_TO_PARALLEL_STREAM_FLUSH_EN.
module serial_to_parallel_stream
  import serial_to_parallel_stream_pkg::*;
#(
  parameter int width     = 8,
  parameter int lane      = 1,
  parameter int msb_first = LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic [lane-1:0]  serial_data,
  output logic             serial_ready,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data,
  input  logic             parallel_ready
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  ,
  input  logic             flush,
  output logic [count_width(beats(width, lane))-1:0] parallel_count
`endif
);

  localparam int BEATS = beats(width, lane);
  localparam int CW    = count_width(BEATS);
  localparam int CNTW  = $clog2(BEATS);
  localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);

  if (width % lane != 0) begin : g_bad_ratio
    $error("serial_to_parallel_stream: width must be a multiple of lane");
  end
  if (width / lane < 2) begin : g_bad_beats
    $error("serial_to_parallel_stream: width/lane must be at least 2");
  end

  logic [CNTW-1:0]  cnt;
  logic [width-1:0] acc;
  logic             last_slot;
  logic             slot_free;
  logic             beat_take;
  logic             load;
  logic [width-1:0] beat_word;
  logic [width-1:0] load_word;

  // Position a beat at its slot; the bit order only changes the shift amount.
  function automatic logic [width-1:0] place(input logic [lane-1:0] beat,
                                             input logic [CNTW-1:0] slot);
    logic [width-1:0] w;
    w = {{(width - lane){1'b0}}, beat};
    if (msb_first == MSB_FIRST) return w << (width - lane - int'(slot) * lane);
    else                        return w << (int'(slot) * lane);
  endfunction

  assign last_slot = (cnt == LAST);
  assign beat_word = place(serial_data, cnt);
  assign beat_take = serial_valid && serial_ready;
  assign load_word = acc | (beat_take ? beat_word : '0);

`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  logic [CW-1:0]       load_count;
  logic                flush_take;
  logic [width+CW-1:0] slot_data;

  // A flush always produces a word, so it must wait for output space.
  assign serial_ready = flush ? slot_free : (!last_slot || slot_free);
  assign flush_take   = flush && !serial_valid && serial_ready && (cnt != '0);
  assign load         = (beat_take && (last_slot || flush)) || flush_take;
  assign load_count   = CW'(cnt) + (beat_take ? CW'(1) : CW'(0));

  s2p_out_slot #(.dw(width + CW)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ({load_count, load_word}),
    .take      (parallel_ready),
    .valid     (parallel_valid),
    .data      (slot_data),
    .slot_free (slot_free)
  );

  assign parallel_data  = slot_data[width-1:0];
  assign parallel_count = slot_data[width +: CW];
`else
  assign serial_ready = !last_slot || slot_free;
  assign load         = beat_take && last_slot;

  s2p_out_slot #(.dw(width)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_word),
    .take      (parallel_ready),
    .valid     (parallel_valid),
    .data      (parallel_data),
    .slot_free (slot_free)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
    end else if (beat_take) begin
      cnt <= cnt + CNTW'(1);
      acc <= acc | beat_word;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Scoreboard bench for serial_to_parallel_stream: an 8x1 LSB-first instance and two
// 16x4 instances (MSB- and LSB-first) fed from the same beat stream.
module tb_serial_to_parallel_stream;

  logic clk;
  logic rst;

  logic       s8_valid;
  logic [0:0] s8_data;
  logic       s8_ready;
  logic       p8_valid;
  logic [7:0] p8_data;
  logic       p8_ready;

  logic        s4_valid;
  logic [3:0]  s4_data;
  logic        sm_ready;
  logic        sl_ready;
  logic        pm_valid;
  logic [15:0] pm_data;
  logic        pl_valid;
  logic [15:0] pl_data;
  logic        p4_ready;

`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  logic       flush4;
  logic [3:0] p8_count;
  logic [2:0] pm_count;
  logic [2:0] pl_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  q8[$];
  logic [15:0] qm[$];
  logic [15:0] ql[$];
  logic [7:0]  e8;
  logic [15:0] em;
  logic [15:0] el;

  serial_to_parallel_stream #(.width(8), .lane(1), .msb_first(0)) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (s8_valid),
    .serial_data    (s8_data),
    .serial_ready   (s8_ready),
    .parallel_valid (p8_valid),
    .parallel_data  (p8_data),
    .parallel_ready (p8_ready)
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    ,
    .flush          (1'b0),
    .parallel_count (p8_count)
`endif
  );

  serial_to_parallel_stream #(.width(16), .lane(4), .msb_first(1)) u_dut_m (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (s4_valid),
    .serial_data    (s4_data),
    .serial_ready   (sm_ready),
    .parallel_valid (pm_valid),
    .parallel_data  (pm_data),
    .parallel_ready (p4_ready)
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    ,
    .flush          (flush4),
    .parallel_count (pm_count)
`endif
  );

  serial_to_parallel_stream #(.width(16), .lane(4), .msb_first(0)) u_dut_l (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (s4_valid),
    .serial_data    (s4_data),
    .serial_ready   (sl_ready),
    .parallel_valid (pl_valid),
    .parallel_data  (pl_data),
    .parallel_ready (p4_ready)
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    ,
    .flush          (flush4),
    .parallel_count (pl_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitors: every word taken by the consumer must match the queue head.
  always @(negedge clk) begin
    if (!rst && p8_valid && p8_ready) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("[TB] FAIL word8_unexpected got=%h expected none", p8_data);
      end else begin
        e8 = q8.pop_front();
        if (p8_data !== e8) begin
          bad++;
          $display("[TB] FAIL word8 got=%h expected=%h", p8_data, e8);
        end
      end
    end
    if (!rst && pm_valid && p4_ready) begin
      total++;
      if (qm.size() == 0) begin
        bad++;
        $display("[TB] FAIL word_msb_unexpected got=%h expected none", pm_data);
      end else begin
        em = qm.pop_front();
        if (pm_data !== em) begin
          bad++;
          $display("[TB] FAIL word_msb got=%h expected=%h", pm_data, em);
        end
      end
    end
    if (!rst && pl_valid && p4_ready) begin
      total++;
      if (ql.size() == 0) begin
        bad++;
        $display("[TB] FAIL word_lsb_unexpected got=%h expected none", pl_data);
      end else begin
        el = ql.pop_front();
        if (pl_data !== el) begin
          bad++;
          $display("[TB] FAIL word_lsb got=%h expected=%h", pl_data, el);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send8(input logic b);
    int n;
    s8_valid = 1'b1;
    s8_data  = b;
    n = 0;
    @(negedge clk);
    while (!s8_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s8_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL beat8_accept got ready=%b expected 1", s8_ready);
    end
    @(posedge clk);
    #1;
    s8_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] b);
    int n;
    s4_valid = 1'b1;
    s4_data  = b;
    n = 0;
    @(negedge clk);
    while (!(sm_ready && sl_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!(sm_ready && sl_ready)) begin
      total++;
      bad++;
      $display("[TB] FAIL beat4_accept got ready=%b%b expected 11", sm_ready, sl_ready);
    end
    @(posedge clk);
    #1;
    s4_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || qm.size() != 0 || ql.size() != 0) && n < 60) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (q8.size() != 0 || qm.size() != 0 || ql.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d/%0d/%0d expected 0/0/0",
               q8.size(), qm.size(), ql.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] w;
    w = 8'h3C;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (p8_valid !== 1'b0 || p8_data !== 8'h00 || pm_valid !== 1'b0 || pl_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got v=%b d=%h expected v=0 d=00", p8_valid, p8_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s8_ready !== 1'b1 || sm_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got=%b%b expected 11", s8_ready, sm_ready);
    end
    @(posedge clk);
    #1;
    p8_ready = 1'b1;
    for (int i = 0; i < 3; i++) send8(1'b1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (p8_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midword_reset_valid got=%b expected 0", p8_valid);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    q8.push_back(w);
    for (int i = 0; i < 8; i++) send8(w[i]);
    drain();
  endtask

  task automatic test_basic();
    logic [7:0] w1;
    logic [7:0] w2;
    int t1;
    w1 = 8'h4D;
    w2 = 8'hB2;
    p8_ready = 1'b1;
    q8.push_back(w1);
    q8.push_back(w2);
    for (int i = 0; i < 7; i++) send8(w1[i]);
    total++;
    if (p8_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_early_valid got=%b expected 0", p8_valid);
    end
    send8(w1[7]);
    s8_valid = 1'b1;
    s8_data  = w2[0];
    @(negedge clk);
    t1 = cyc;
    total++;
    if (p8_valid !== 1'b1 || p8_data !== w1 || s8_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_latency got v=%b d=%h expected v=1 d=%h", p8_valid, p8_data, w1);
    end
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    total++;
    if (p8_count !== 4'd8) begin
      bad++;
      $display("[TB] FAIL basic_count got=%0d expected 8", p8_count);
    end
`endif
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) send8(w2[i]);
    @(negedge clk);
    total++;
    if (p8_valid !== 1'b1 || p8_data !== w2 || cyc - t1 != 8) begin
      bad++;
      $display("[TB] FAIL basic_rate got v=%b d=%h gap=%0d expected v=1 d=%h gap=8",
               p8_valid, p8_data, cyc - t1, w2);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h96;
    w2 = 8'h5B;
    p8_ready = 1'b0;
    q8.push_back(w1);
    q8.push_back(w2);
    for (int i = 0; i < 8; i++) send8(w1[i]);
    for (int i = 0; i < 7; i++) send8(w2[i]);
    s8_valid = 1'b1;
    s8_data  = w2[7];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (s8_ready !== 1'b0 || p8_valid !== 1'b1 || p8_data !== w1) begin
        bad++;
        $display("[TB] FAIL bp_hold got rdy=%b v=%b d=%h expected rdy=0 v=1 d=%h",
                 s8_ready, p8_valid, p8_data, w1);
      end
    end
    @(posedge clk);
    #1;
    p8_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s8_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release got rdy=%b expected 1", s8_ready);
    end
    @(posedge clk);
    #1;
    s8_valid = 1'b0;
    @(negedge clk);
    total++;
    if (p8_valid !== 1'b1 || p8_data !== w2) begin
      bad++;
      $display("[TB] FAIL bp_swap got v=%b d=%h expected v=1 d=%h", p8_valid, p8_data, w2);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_lane_order();
    logic [15:0] m;
    logic [15:0] l;
    logic [3:0]  b;
    p4_ready = 1'b1;
    qm.push_back(16'hABCD);
    ql.push_back(16'hDCBA);
    send4(4'hA);
    send4(4'hB);
    send4(4'hC);
    send4(4'hD);
    @(negedge clk);
    total++;
    if (pm_valid !== 1'b1 || pm_data !== 16'hABCD || pl_valid !== 1'b1 || pl_data !== 16'hDCBA) begin
      bad++;
      $display("[TB] FAIL lane_order got msb=%h lsb=%h expected msb=abcd lsb=dcba", pm_data, pl_data);
    end
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    total++;
    if (pm_count !== 3'd4 || pl_count !== 3'd4) begin
      bad++;
      $display("[TB] FAIL lane_count got=%0d/%0d expected 4/4", pm_count, pl_count);
    end
`endif
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      m = '0;
      l = '0;
      for (int k = 0; k < 4; k++) begin
        b = 4'($urandom_range(0, 15));
        m = {m[11:0], b};
        l = l | (16'(b) << (4 * k));
        if (k == 3) begin
          qm.push_back(m);
          ql.push_back(l);
        end
        send4(b);
      end
    end
    drain();
  endtask

`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  task automatic do_flush();
    int n;
    flush4 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(sm_ready && sl_ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!(sm_ready && sl_ready)) begin
      total++;
      bad++;
      $display("[TB] FAIL flush_accept got ready=%b%b expected 11", sm_ready, sl_ready);
    end
    @(posedge clk);
    #1;
    flush4 = 1'b0;
  endtask

  task automatic test_flush();
    p4_ready = 1'b1;
    qm.push_back(16'h5600);
    ql.push_back(16'h0065);
    send4(4'h5);
    send4(4'h6);
    do_flush();
    @(negedge clk);
    total++;
    if (pl_valid !== 1'b1 || pl_data !== 16'h0065 || pl_count !== 3'd2 || pm_count !== 3'd2) begin
      bad++;
      $display("[TB] FAIL flush_partial got v=%b d=%h n=%0d expected v=1 d=0065 n=2",
               pl_valid, pl_data, pl_count);
    end
    @(posedge clk);
    #1;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (pm_valid !== 1'b0 || pl_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL flush_empty got v=%b%b expected 00", pm_valid, pl_valid);
      end
    end
    @(posedge clk);
    #1;
    qm.push_back(16'h3700);
    ql.push_back(16'h0073);
    send4(4'h3);
    flush4 = 1'b1;
    send4(4'h7);
    flush4 = 1'b0;
    @(negedge clk);
    total++;
    if (pl_valid !== 1'b1 || pl_data !== 16'h0073 || pl_count !== 3'd2) begin
      bad++;
      $display("[TB] FAIL flush_with_beat got v=%b d=%h n=%0d expected v=1 d=0073 n=2",
               pl_valid, pl_data, pl_count);
    end
    @(posedge clk);
    #1;
    drain();
  endtask
`endif

  initial begin
    rst      = 1'b1;
    s8_valid = 1'b0;
    s8_data  = '0;
    p8_ready = 1'b0;
    s4_valid = 1'b0;
    s4_data  = '0;
    p4_ready = 1'b1;
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    flush4   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_lane_order();
`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
    test_flush();
`endif
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
